updown_sweep_ctrl: RTL
======================

Name: updown_sweep_ctrl

Overview:
- Sequencer for the 4-bit up/down counter datapath.
- On start, loads a lower bound into the counter, then drives enable/select so the counter sweeps lo→hi→lo for a programmed number of round trips.
- Pulses done at the end, or runs continuously until aborted.
- Sits between control logic (or the bench) and the counter's load/enable/select/data inputs, and observes the counter's out.

Parameters:
- WIDTH, 4: counter data width.
- SWEEP_W, 4: width of the sweep-count operand and status.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence; sampled in IDLE only.
- abort  in  1  terminate the active sequence.
- lo  in  WIDTH  lower bound; latched at start.
- hi  in  WIDTH  upper bound; latched at start.
- sweeps  in  SWEEP_W  round trips to run; 0 means continuous. Latched at start.
- cnt_in  in  WIDTH  counter out, registered in the counter.
- ctr_data  out  WIDTH  counter load value; equals latched lo.
- ctr_load  out  1  counter load strobe.
- ctr_en  out  1  counter enable.
- ctr_sel  out  1  counter direction: 1 = up, 0 = down.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start is rejected.
- sweep_cnt  out  SWEEP_W  completed round trips in the current sequence.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; all 1-bit outputs 0; sweep_cnt=0; latched lo/hi/sweeps=0.
- FSM states: IDLE, LOAD, UP, DOWN, DONE.
- ctr_en, ctr_sel and ctr_load are combinational from state and cnt_in. Everything else is registered.
- IDLE:
  - start && lo<hi: latch operands, clear sweep_cnt, go to LOAD.
  - start && lo>=hi: err=1 next cycle, stay in IDLE.
- LOAD: ctr_load=1, ctr_en=0. Unconditionally go to UP. The counter holds lo from the next cycle.
- UP:
  - ctr_sel=1; ctr_en = (cnt_in < hi_q).
  - cnt_in >= hi_q: go to DOWN. This gives one turnaround dwell cycle with ctr_en=0.
- DOWN:
  - ctr_sel=0; ctr_en = (cnt_in > lo_q).
  - cnt_in <= lo_q: sweep_cnt+1. If sweeps_q!=0 and sweep_cnt+1==sweeps_q, go to DONE; otherwise go to UP.
- Comparisons use >= / <= so a counter disturbed out of range (e.g. its own reset) still converges.
- DONE: done=1 for exactly one cycle, then go to IDLE. sweep_cnt holds until the next accepted start.
- Continuous mode (sweeps=0): sweep_cnt wraps modulo 2^SWEEP_W; done never fires.
- abort in LOAD/UP/DOWN: next state IDLE, no done. Outputs are 0 from that cycle's edge; sweep_cnt holds.
- abort has priority over every transition, including the DOWN→DONE transition in the same cycle.
- start while busy: ignored. abort in IDLE or DONE: ignored.
- Timing example, lo=2, hi=4, sweeps=1, start sampled at edge 0:
  - LOAD in cycle 1.
  - cnt_in reads 2,3,4(dwell),4,3,2 in cycles 2–7.
  - done high in cycle 8; IDLE in cycle 9.
- Reset mid-sequence: immediate IDLE; all outputs 0 asynchronously.

Optional Feature:
- Macro: SWEEP_HOLD_EN.
- When defined: adds input port hold, 1 bit.
  - While hold=1 in LOAD/UP/DOWN: state, sweep_cnt and operands are frozen, and ctr_en=0 and ctr_load=0.
  - ctr_sel keeps its state value.
  - abort still overrides hold.
  - hold has no effect in IDLE or DONE.
- When undefined: no hold port; behaviour as above.

Decomposition:
- Shared package updown_sweep_pkg:
  - state encoding constants (IDLE=0 … DONE=4, 3-bit);
  - direction constants SEL_UP=1, SEL_DOWN=0;
  - default WIDTH/SWEEP_W.
- One sub-module, sweep_tracker: holds the sweep_cnt register, the increment, and the sweeps_q terminal-count compare; outputs last_sweep. The FSM stays in the top.

Test Plan:
- lo=2, hi=4, sweeps=1, start → LOAD cycle 1 with ctr_data=2; cnt sequence 2,3,4,4,3,2; done pulse in cycle 8; sweep_cnt=1.
- lo=0, hi=15, sweeps=3 → three full sweeps; sweep_cnt reaches 3; exactly one done; no value outside 0..15.
- lo=5, hi=5, start → err pulse one cycle later; busy stays 0; ctr_load never asserted.
- sweeps=0, lo=1, hi=3, run ≥20 sweeps, then abort in UP → busy=0 next cycle, no done, ctr_en=0, sweep_cnt wrapped correctly.
- Reset asserted in DOWN with cnt=7 → all outputs 0 immediately, asynchronously; later start with lo=3, hi=6 behaves normally.
- Under SWEEP_HOLD_EN, hold=1 for 5 cycles in UP at cnt=3 → cnt_in stays 3 and state is frozen; after release, sequence resumes and done is delayed by exactly 5 cycles.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep sequencer: state encoding,
// counter direction constants and default operand widths.
package updown_sweep_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_SWEEP_W = 4;

  // Counter direction as seen on ctr_sel.
  localparam logic SEL_UP   = 1'b1;
  localparam logic SEL_DOWN = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_sweep_tracker.sv
// Round-trip bookkeeping: latches the requested sweep count, counts completed
// round trips (wrapping in continuous mode) and flags the final round trip.
module sweep_tracker
  import updown_sweep_pkg::*;
#(
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic [SWEEP_W-1:0] sweeps_i,
  input  logic               inc_i,
  output logic [SWEEP_W-1:0] sweep_cnt_o,
  output logic               last_sweep_o
);

  logic [SWEEP_W-1:0] sweeps_q;
  logic [SWEEP_W-1:0] sweep_cnt_q;
  logic [SWEEP_W-1:0] sweep_cnt_d;

  assign sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);

  // Latch the target and clear the count on an accepted start; count completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
    end else if (clr_i) begin
      sweeps_q    <= sweeps_i;
      sweep_cnt_q <= '0;
    end else if (inc_i) begin
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // A zero target means continuous mode, so there is never a last sweep.
  assign last_sweep_o = (sweeps_q != '0) && (sweep_cnt_d == sweeps_q);
  assign sweep_cnt_o  = sweep_cnt_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a 4-bit up/down counter: loads lo, sweeps lo->hi->lo for a
// programmed number of round trips (0 = until abort), pulses done at the end.
// Optional macro SWEEP_HOLD_EN adds a hold input that freezes an active sequence.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [WIDTH-1:0]   cnt_in,
  output logic [WIDTH-1:0]   ctr_data,
  output logic               ctr_load,
  output logic               ctr_en,
  output logic               ctr_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  state_t           state_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic hold_act;
  logic accept;
  logic at_top;
  logic at_bot;
  logic sweep_inc;
  logic last_sweep;

`ifdef SWEEP_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // Inclusive compares so a counter knocked out of range still turns around.
  assign at_top    = (cnt_in >= hi_q);
  assign at_bot    = (cnt_in <= lo_q);
  assign accept    = (state_q == ST_IDLE) && start && (lo < hi);
  assign sweep_inc = (state_q == ST_DOWN) && at_bot && !abort && !hold_act;

  sweep_tracker #(
    .SWEEP_W (SWEEP_W)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (accept),
    .sweeps_i     (sweeps),
    .inc_i        (sweep_inc),
    .sweep_cnt_o  (sweep_cnt),
    .last_sweep_o (last_sweep)
  );

  // Sequence FSM with registered status; abort wins over hold and every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (lo < hi) begin
              lo_q    <= lo;
              hi_q    <= hi;
              busy_q  <= 1'b1;
              state_q <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!hold_act) begin
            state_q <= ST_UP;
          end
        end
        ST_UP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!hold_act && at_top) begin
            state_q <= ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!hold_act && at_bot) begin
            if (last_sweep) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_UP;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Counter controls decode straight from state and the live counter value.
  always_comb begin
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    ctr_sel  = SEL_DOWN;
    case (state_q)
      ST_LOAD: ctr_load = !hold_act;
      ST_UP: begin
        ctr_sel = SEL_UP;
        ctr_en  = !hold_act && !at_top;
      end
      ST_DOWN: begin
        ctr_sel = SEL_DOWN;
        ctr_en  = !hold_act && !at_bot;
      end
      default: begin
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        ctr_sel  = SEL_DOWN;
      end
    endcase
  end

  assign ctr_data = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
